// File: rtl/wb_lsu_pkg.sv
// Shared types and helpers for the Wishbone load/store initiator.
package wb_lsu_pkg;

  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} size_e;
  typedef enum logic [1:0] {OK = 2'd0, MISALIGN = 2'd1, BUSERR = 2'd2, TIMEOUT = 2'd3} cause_e;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_e;

  // Size code 3 is reserved and behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return off[0];
      default: return off != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_lsu_lane.sv
// Byte-lane logic: store select/replication and load alignment/extension.
module wb_lsu_lane
  import wb_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_data,
  output logic [3:0]  sel,
  output logic [31:0] st_lanes,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_off,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    sel      = 4'b1111;
    st_lanes = st_data;
    case (st_size)
      BYTE: begin
        sel      = 4'b0001 << st_off;
        st_lanes = {4{st_data[7:0]}};
      end
      HALF: begin
        sel      = 4'b0011 << st_off;
        st_lanes = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted = ld_raw >> {ld_off, 3'b000};
    ld_data = shifted;
    case (ld_size)
      BYTE:    ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
      HALF:    ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Single-outstanding pipelined Wishbone initiator for LSU load/store requests.
//   state | meaning
//   IDLE  | ready for a request, no bus activity
//   REQ   | cyc/stb asserted, waiting for the slave to take the strobe
//   WAIT  | strobe taken, cyc held until ack/err or timeout
//   RESP  | one-cycle response pulse to the LSU
module wb_lsu_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic [1:0]  rsp_cause_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic        wb_stall_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic [31:0] wb_dat_i
);
  import wb_lsu_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

  state_e           state;
  logic [CNT_W-1:0] tmo_cnt;
  logic [CNT_W-1:0] tmo_nxt;
  logic [1:0]       ld_size;
  logic [1:0]       ld_off;
  logic             ld_uns;
  logic [3:0]       lane_sel;
  logic [31:0]      lane_wdat;
  logic [31:0]      lane_rdata;
  logic             bus_done;
  logic             tmo_hit;

  wb_lsu_lane u_lane (
    .st_size     (req_size_i),
    .st_off      (req_addr_i[1:0]),
    .st_data     (req_wdata_i),
    .sel         (lane_sel),
    .st_lanes    (lane_wdat),
    .ld_size     (ld_size),
    .ld_off      (ld_off),
    .ld_unsigned (ld_uns),
    .ld_raw      (wb_dat_i),
    .ld_data     (lane_rdata)
  );

  // A stalled strobe was not taken, so any ack/err seen with it is ignored.
  assign bus_done = (wb_ack_i | wb_err_i) &
                    (((state == REQ) & ~wb_stall_i) | (state == WAIT));
  // tmo_nxt counts the current cycle, so cyc stays high exactly TIMEOUT_CYCLES cycles.
  assign tmo_nxt  = tmo_cnt + 1'b1;
  assign tmo_hit  = (tmo_nxt == TMO_MAX);

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_cause_o <= '0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_dat_o    <= '0;
      wb_sel_o    <= '0;
      tmo_cnt     <= '0;
      ld_size     <= '0;
      ld_off      <= '0;
      ld_uns      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_o <= 1'b0;
            wb_we_o     <= req_we_i;
            wb_adr_o    <= {req_addr_i[31:2], 2'b00};
            wb_sel_o    <= lane_sel;
            wb_dat_o    <= lane_wdat;
            ld_size     <= req_size_i;
            ld_off      <= req_addr_i[1:0];
            ld_uns      <= req_unsigned_i;
            tmo_cnt     <= '0;
            if (is_misaligned(req_size_i, req_addr_i[1:0])) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_cause_o <= MISALIGN;
              rsp_rdata_o <= '0;
            end else begin
              state    <= REQ;
              wb_cyc_o <= 1'b1;
              wb_stb_o <= 1'b1;
            end
          end
        end
        REQ, WAIT: begin
          tmo_cnt <= tmo_nxt;
          if (bus_done) begin
            state       <= RESP;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_cause_o <= wb_err_i ? BUSERR : OK;
            rsp_rdata_o <= (wb_err_i || wb_we_o) ? 32'h0 : lane_rdata;
          end else if (tmo_hit) begin
            state       <= RESP;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_cause_o <= TIMEOUT;
            rsp_rdata_o <= '0;
          end else if (state == REQ && !wb_stall_i) begin
            state    <= WAIT;
            wb_stb_o <= 1'b0;
          end
        end
        RESP: begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
          rsp_rdata_o <= '0;
          rsp_cause_o <= '0;
          req_ready_o <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Scoreboard bench for wb_lsu_master against a small pipelined Wishbone memory slave.
module tb_wb_lsu_master;

  logic        clk;
  logic        wb_rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_cause_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stall_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic [31:0] wb_dat_i;

  wb_lsu_master #(.TIMEOUT_CYCLES(8)) dut (
    .wb_clk_i       (clk),
    .wb_rst_ni      (wb_rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_cause_o    (rsp_cause_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel_o),
    .wb_stall_i     (wb_stall_i),
    .wb_ack_i       (wb_ack_i),
    .wb_err_i       (wb_err_i),
    .wb_dat_i       (wb_dat_i)
  );

  typedef struct {
    logic [1:0]  cause;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc_n = 0;

  logic [31:0] mem [64];
  bit          cfg_err = 0;
  bit          cfg_silent = 0;
  int          stall_left = 0;
  int          n_cyc = 0;
  int          n_stb = 0;
  logic [3:0]  last_sel = '0;
  logic [31:0] last_dat = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @cycle %0d", tag, got, exp, cyc_n);
    end
  endtask

  // Memory slave: responds one cycle after taking an unstalled strobe.
  initial begin
    bit          pend = 0;
    bit          prev_cyc = 0;
    logic [31:0] rd_word = '0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    wb_stall_i = 0; wb_ack_i = 0; wb_err_i = 0; wb_dat_i = '0;
    forever begin
      @(negedge clk);
      wb_ack_i = 0;
      wb_err_i = 0;
      wb_dat_i = 32'h5A5A_5A5A;
      if (pend) begin
        wb_ack_i = 1;
        wb_err_i = cfg_err;
        wb_dat_i = rd_word;
        pend = 0;
      end
      if (prev_cyc && !wb_cyc_o) wb_ack_i = 1;
      prev_cyc = wb_cyc_o;
      if (wb_cyc_o) n_cyc++;
      if (wb_stb_o) n_stb++;
      wb_stall_i = 0;
      if (wb_cyc_o && wb_stb_o) begin
        if (stall_left > 0) begin
          wb_stall_i = 1;
          stall_left--;
        end else if (!cfg_silent) begin
          pend     = 1;
          rd_word  = mem[wb_adr_o[7:2]];
          last_sel = wb_sel_o;
          last_dat = wb_dat_o;
          if (wb_we_o)
            for (int b = 0; b < 4; b++)
              if (wb_sel_o[b]) mem[wb_adr_o[7:2]][8*b +: 8] = wb_dat_o[8*b +: 8];
        end
      end
    end
  end

  // Response monitor: pops the scoreboard on every response pulse.
  initial begin
    bit prev_rsp = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (prev_rsp) chk("ready_after_rsp", req_ready_o, 1);
      prev_rsp = rsp_valid_o;
      if (rsp_valid_o) begin
        if (sb.size() == 0) chk("unexpected_rsp", rsp_valid_o, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_cause", rsp_cause_o, e.cause);
          chk("rsp_rdata", rsp_rdata_o, e.rdata);
          chk("rsp_cycle", 32'(cyc_n), 32'(e.cyc));
        end
      end else if (wb_rst_ni) begin
        chk("idle_rdata_zero", rsp_rdata_o, 0);
        chk("idle_cause_zero", rsp_cause_o, 0);
      end
    end
  end

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input bit push,
                       input logic [1:0] ecause, input logic [31:0] erd, input int lat);
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      chk("ready_timeout", req_ready_o, 1);
      return;
    end
    req_we_i = we; req_addr_i = addr; req_wdata_i = wdata;
    req_size_i = size; req_unsigned_i = uns; req_valid_i = 1;
    @(posedge clk);
    #1;
    req_valid_i = 0;
    if (push) sb.push_back('{cause: ecause, rdata: erd, cyc: cyc_n + lat - 1});
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    wb_rst_ni = 0; req_valid_i = 0; req_we_i = 0; req_addr_i = '0;
    req_wdata_i = '0; req_size_i = '0; req_unsigned_i = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready_o, 1);
    chk("rst_outs", {rsp_valid_o, wb_cyc_o, wb_stb_o, wb_we_o, rsp_cause_o}, 0);
    chk("rst_vecs", wb_adr_o | wb_dat_o | rsp_rdata_o | {28'h0, wb_sel_o}, 0);
    wb_rst_ni = 1;

    n_cyc = 0;
    issue(1, 32'h100, 32'hDEAD_BEEF, 2'd2, 0, 1, 2'd0, 32'h0, 3);
    wait_done();
    chk("st_word_sel", last_sel, 4'b1111);
    chk("st_word_dat", last_dat, 32'hDEAD_BEEF);
    chk("zero_wait_cyc_len", 32'(n_cyc), 2);
    issue(0, 32'h100, 32'h0, 2'd2, 0, 1, 2'd0, 32'hDEAD_BEEF, 3);
    wait_done();

    issue(1, 32'h100, 32'h80FF_7F01, 2'd2, 0, 1, 2'd0, 32'h0, 3);
    issue(0, 32'h103, 32'h0, 2'd0, 0, 1, 2'd0, 32'hFFFF_FF80, 3);
    issue(0, 32'h103, 32'h0, 2'd0, 1, 1, 2'd0, 32'h0000_0080, 3);
    issue(0, 32'h102, 32'h0, 2'd1, 0, 1, 2'd0, 32'hFFFF_80FF, 3);
    issue(0, 32'h101, 32'h0, 2'd0, 0, 1, 2'd0, 32'h0000_007F, 3);
    issue(0, 32'h100, 32'h0, 2'd1, 1, 1, 2'd0, 32'h0000_7F01, 3);
    issue(0, 32'h100, 32'h0, 2'd0, 0, 1, 2'd0, 32'h0000_0001, 3);
    issue(0, 32'h100, 32'h0, 2'd3, 0, 1, 2'd0, 32'h80FF_7F01, 3);
    wait_done();

    issue(1, 32'h101, 32'h0000_00AB, 2'd0, 0, 1, 2'd0, 32'h0, 3);
    wait_done();
    chk("st_byte_sel", last_sel, 4'b0010);
    chk("st_byte_dat", last_dat, 32'hABAB_ABAB);
    issue(0, 32'h100, 32'h0, 2'd2, 0, 1, 2'd0, 32'h80FF_AB01, 3);
    issue(1, 32'h102, 32'h0000_1234, 2'd1, 0, 1, 2'd0, 32'h0, 3);
    wait_done();
    chk("st_half_sel", last_sel, 4'b1100);
    chk("st_half_dat", last_dat, 32'h1234_1234);
    issue(0, 32'h100, 32'h0, 2'd2, 0, 1, 2'd0, 32'h1234_AB01, 3);
    wait_done();

    n_cyc = 0;
    issue(0, 32'h102, 32'h0, 2'd2, 0, 1, 2'd1, 32'h0, 1);
    issue(1, 32'h101, 32'h0, 2'd1, 0, 1, 2'd1, 32'h0, 1);
    issue(0, 32'h101, 32'h0, 2'd2, 1, 1, 2'd1, 32'h0, 1);
    wait_done();
    chk("misalign_no_cyc", 32'(n_cyc), 0);

    n_stb = 0;
    stall_left = 3;
    issue(0, 32'h100, 32'h0, 2'd2, 0, 1, 2'd0, 32'h1234_AB01, 6);
    wait_done();
    chk("stall_stb_len", 32'(n_stb), 4);

    cfg_err = 1;
    issue(0, 32'h100, 32'h0, 2'd2, 0, 1, 2'd2, 32'h0, 3);
    wait_done();
    cfg_err = 0;

    n_cyc = 0;
    cfg_silent = 1;
    issue(0, 32'h100, 32'h0, 2'd2, 0, 1, 2'd3, 32'h0, 9);
    wait_done();
    cfg_silent = 0;
    chk("timeout_cyc_len", 32'(n_cyc), 8);
    issue(0, 32'h102, 32'h0, 2'd1, 1, 1, 2'd0, 32'h0000_1234, 3);
    wait_done();

    cfg_silent = 1;
    issue(0, 32'h100, 32'h0, 2'd2, 0, 0, 2'd0, 32'h0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("wait_state_bus", {wb_cyc_o, wb_stb_o}, 2'b10);
    wb_rst_ni = 0;
    @(posedge clk);
    #1;
    chk("rst_mid_cyc", wb_cyc_o, 0);
    chk("rst_mid_ready", req_ready_o, 1);
    chk("rst_mid_rsp", rsp_valid_o, 0);
    @(negedge clk);
    wb_rst_ni = 1;
    repeat (12) @(negedge clk);
    cfg_silent = 0;
    issue(0, 32'h100, 32'h0, 2'd2, 0, 1, 2'd0, 32'h1234_AB01, 3);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_lsu_master.md
# wb_lsu_master

Single-outstanding Wishbone (pipelined) initiator that turns the core's load/store requests into bus cycles on a data-memory port such as port1 of the dual-port testbench memory. It handles byte-lane select generation, store-data replication, load alignment with sign/zero extension, misalignment detection and a bus timeout. It sits between the LSU and the data-side Wishbone interconnect.

## Interface
- `TIMEOUT_CYCLES`, 255: cycles of `wb_cyc_o` without `ack`/`err` before the cycle is abandoned; must be ≥1.
- `wb_clk_i` in 1: clock.
- `wb_rst_ni` in 1: reset, synchronous, active-low.
- `req_valid_i` in 1: request present.
- `req_ready_o` out 1: request accepted when `valid && ready`.
- `req_we_i` in 1: 1 = store, 0 = load.
- `req_addr_i` in 32: byte address.
- `req_wdata_i` in 32: store data, right-aligned.
- `req_size_i` in 2: 0 = byte, 1 = half, 2 = word; 3 is reserved and treated as word.
- `req_unsigned_i` in 1: zero-extend loads.
- `rsp_valid_o` out 1: one-cycle response pulse; there is no backpressure.
- `rsp_rdata_o` out 32: aligned, extended load data; 0 for stores and errors.
- `rsp_cause_o` out 2: 0 = OK, 1 = misaligned, 2 = bus error, 3 = timeout.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1: Wishbone master controls.
- `wb_adr_o` out 32: word address, `{req_addr[31:2], 2'b00}`.
- `wb_dat_o` out 32: write data.
- `wb_sel_o` out 4: byte enables.
- `wb_stall_i`, `wb_ack_i`, `wb_err_i` in 1: slave responses.
- `wb_dat_i` in 32: read data.

## Operation
- **FSM states:** IDLE, REQ, WAIT, RESP.
  - **IDLE:** `req_ready_o=1`. On accept, register `we`, `adr`, `sel`, `dat`, `size`, `unsigned` and `addr[1:0]`.
    - If misaligned (half with `addr[0]=1`, or word with `addr[1:0]≠0`): go to RESP with cause 1. No bus cycle is issued.
    - Otherwise go to REQ.
  - **REQ:** `cyc=stb=1`.
    - `stall=1`: stay.
    - `stall=0` and `ack`/`err`: go to RESP (combinational slave).
    - `stall=0` otherwise: go to WAIT.
  - **WAIT:** `cyc=1`, `stb=0`. Go to RESP on `ack` or `err`.
  - **RESP:** `rsp_valid_o=1`, `cyc=stb=0`. Next state is IDLE.
- **`sel` generation:** byte → `4'b0001<<a`; half → `4'b0011<<a`; word → `4'b1111`, where `a = addr[1:0]`.
- **Store data:** byte → `{4{wdata[7:0]}}`; half → `{2{wdata[15:0]}}`; word → `wdata`.
- **Load data:** on `ack`, capture `wb_dat_i >> (8*a)`, then take the low 8, 16 or 32 bits. Extend with the top bit unless `unsigned`.
- **Priority:** `err` outranks `ack` when both arrive in the same cycle → cause 2, `rdata=0`.
- **Ignored inputs:** `ack`/`err` in IDLE or RESP, or in REQ while `stall=1`.
- **Timeout:**
  - The counter clears on accept and increments every cycle in REQ or WAIT. Width is `$clog2(TIMEOUT_CYCLES+1)`.
  - When it equals `TIMEOUT_CYCLES` with no `ack`/`err` in that cycle, go to RESP with cause 3 and drop `cyc`/`stb` at the same edge.
  - A late `ack` arriving after this is ignored.
- **Reset:**
  - Returns to IDLE. Every output is 0 except `req_ready_o`, which is 1.
  - Reset mid-cycle drops `cyc`/`stb` at that edge and emits no response.

## Timing
- All outputs are registered (state-decoded). There is no combinational path from Wishbone inputs to Wishbone outputs.
- Zero-wait slave (`stall=0`, `ack` one cycle after `stb`), with accept at edge T:
  - `stb` is high during cycle T+1.
  - `ack` arrives during cycle T+2.
  - `rsp_valid_o` is high during cycle T+3.
  - `req_ready_o` is high again in T+4.
  - Throughput is one transaction per 4 cycles.
- Each cycle of `stall` adds one cycle in REQ. Misaligned requests respond at T+1.
- `wb_adr_o`, `wb_sel_o`, `wb_dat_o` and `wb_we_o` hold stable from REQ through WAIT.
- `rsp_rdata_o` and `rsp_cause_o` are valid only while `rsp_valid_o=1`; they are 0 otherwise.

## Structure
- **Package `wb_lsu_pkg`:** `size_e` (BYTE/HALF/WORD), `cause_e` (OK/MISALIGN/BUSERR/TIMEOUT), `state_e`.
- **Sub-module `wb_lsu_lane`:** purely combinational; generates `sel` and store data, and performs load align/extend. It is reused by the FSM top.

## Test plan
- **Word store then load** (32-bit word store, then a load of the same address, both into the 2-port testbench memory on port1): store `0xDEADBEEF` @ `0x100` → `sel=1111`, cause 0. Load @ `0x100` → `rdata=0xDEADBEEF` at T+3.
- **Byte load, signed vs unsigned:** memory word `0x80FF7F01`. Load byte @ `0x103` signed → `0xFFFFFF80`; unsigned → `0x00000080`. Half @ `0x102` signed → `0xFFFF80FF`.
- **Byte store:** store byte `0xAB` @ `0x101` → `sel=0010`, `dat=0xABABABAB`. Other bytes are unchanged on readback.
- **Misaligned requests:** word @ `0x102` and half @ `0x101` → `rsp_valid` at T+1, cause 1, `cyc` never asserted.
- **Stall and error:** slave holds `stall` for 3 cycles, then `ack` → `stb` high 4 cycles, response at T+6. Slave asserts `err` together with `ack` → cause 2, `rdata=0`.
- **Timeout and reset:** slave silent with `TIMEOUT_CYCLES=8` → `cyc` drops and cause 3 is reported after 8 cycles in REQ/WAIT. Separately, `wb_rst_ni=0` during WAIT → `cyc=0` at the next edge, no `rsp_valid`, `req_ready_o=1`.
